// File: rtl/sc_phase_clkgen.sv
// Non-overlapping two-phase clock generator for a switched-capacitor filter.
// Produces phi1, early phi1 and phi2 with programmable phase and gap lengths.
module sc_phase_clkgen #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [LEN_W-1:0] ph1_len,
    input  logic [LEN_W-1:0] ph2_len,
    input  logic [LEN_W-1:0] nov_len,
    output logic             phi1,
    output logic             phi1e,
    output logic             phi2,
    output logic             period_done,
    output logic [CNT_W-1:0] period_cnt,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        PHI1,
        GAP12,
        PHI2,
        GAP21
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W-1:0] ph2_s_q, ph2_s_d;
    logic [LEN_W-1:0] nov_s_q, nov_s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stop_q, stop_d;
    logic             phi1_q, phi1_d;
    logic             phi1e_q, phi1e_d;
    logic             phi2_q, phi2_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [LEN_W-1:0] ph1_c, ph2_c, nov_c;
    logic             last;

    always_comb begin
        ph1_c = (ph1_len < LEN_W'(2)) ? LEN_W'(2) : ph1_len;
        ph2_c = (ph2_len == '0) ? LEN_W'(1) : ph2_len;
        nov_c = (nov_len == '0) ? LEN_W'(1) : nov_len;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ph2_s_d = ph2_s_q;
        nov_s_d = nov_s_q;
        cnt_d   = cnt_q;
        stop_d  = stop_q;
        last    = (rem_q == '0);
        unique case (state_q)
            IDLE: begin
                stop_d = 1'b0;
                if (enable) begin
                    state_d = PHI1;
                    rem_d   = ph1_c - LEN_W'(1);
                    ph2_s_d = ph2_c;
                    nov_s_d = nov_c;
                end
            end
            PHI1: begin
                if (last) begin
                    state_d = GAP12;
                    rem_d   = nov_s_q - LEN_W'(1);
                end else begin
                    rem_d = rem_q - LEN_W'(1);
                end
            end
            GAP12: begin
                if (last) begin
                    state_d = PHI2;
                    rem_d   = ph2_s_q - LEN_W'(1);
                end else begin
                    rem_d = rem_q - LEN_W'(1);
                end
            end
            PHI2: begin
                if (last) begin
                    state_d = GAP21;
                    rem_d   = nov_s_q - LEN_W'(1);
                end else begin
                    rem_d = rem_q - LEN_W'(1);
                end
            end
            GAP21: begin
                if (last) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    stop_d = 1'b0;
                    if (enable && !stop_q) begin
                        state_d = PHI1;
                        rem_d   = ph1_c - LEN_W'(1);
                        ph2_s_d = ph2_c;
                        nov_s_d = nov_c;
                    end else begin
                        state_d = IDLE;
                        rem_d   = '0;
                    end
                end else begin
                    rem_d = rem_q - LEN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
        // Once enable is seen low mid-period, the period winds down to IDLE.
        if (state_q != IDLE && !enable) begin
            stop_d = 1'b1;
        end
        phi1_d  = (state_d == PHI1);
        phi1e_d = phi1_d && (rem_d != '0);
        phi2_d  = (state_d == PHI2);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == GAP21) && (rem_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            ph2_s_q <= '0;
            nov_s_q <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            phi1_q  <= 1'b0;
            phi1e_q <= 1'b0;
            phi2_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ph2_s_q <= ph2_s_d;
            nov_s_q <= nov_s_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            phi1_q  <= phi1_d;
            phi1e_q <= phi1e_d;
            phi2_q  <= phi2_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign phi1        = phi1_q;
    assign phi1e       = phi1e_q;
    assign phi2        = phi2_q;
    assign period_done = done_q;
    assign period_cnt  = cnt_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_sc_phase_clkgen.sv
// Directed bench for sc_phase_clkgen: waveforms captured per cycle
// and compared against hand-derived bit patterns.
module tb_sc_phase_clkgen;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] ph1_len, ph2_len, nov_len;
    logic       phi1, phi1e, phi2, period_done, busy;
    logic [3:0] period_cnt;

    int checks;
    int errors;
    int dcount;
    logic ov;
    logic [31:0] p1, p1e, p2, pd, pb;

    sc_phase_clkgen #(.LEN_W(8), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .ph1_len    (ph1_len),
        .ph2_len    (ph2_len),
        .nov_len    (nov_len),
        .phi1       (phi1),
        .phi1e      (phi1e),
        .phi2       (phi2),
        .period_done(period_done),
        .period_cnt (period_cnt),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample n cycles at negedge; first cycle ends up in the MSB.
    task automatic cap(input int n);
        p1 = '0; p1e = '0; p2 = '0; pd = '0; pb = '0;
        repeat (n) begin
            @(negedge clk);
            p1  = {p1[30:0], phi1};
            p1e = {p1e[30:0], phi1e};
            p2  = {p2[30:0], phi2};
            pd  = {pd[30:0], period_done};
            pb  = {pb[30:0], busy};
            ov  = ov | (phi1 & phi2);
            dcount += int'(period_done);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        dcount  = 0;
        ov      = 1'b0;
        rst_n   = 1'b0;
        enable  = 1'b0;
        ph1_len = 8'd0;
        ph2_len = 8'd0;
        nov_len = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_outs", {26'd0, phi1, phi1e, phi2, period_done, busy},
              32'd0);
        check("rst_cnt", period_cnt, 32'd0);
        rst_n = 1'b1;

        // Basic 4/1/3 sequence
        @(negedge clk);
        ph1_len = 8'd4; nov_len = 8'd1; ph2_len = 8'd3; enable = 1'b1;
        cap(9);
        check("basic_phi1", p1, 32'b111100000);
        check("basic_phi1e", p1e, 32'b111000000);
        check("basic_phi2", p2, 32'b000001110);
        check("basic_done", pd, 32'b000000001);
        check("basic_busy", pb, 32'b111111111);
        check("basic_cnt0", period_cnt, 32'd0);
        cap(1);
        check("cnt1", period_cnt, 32'd1);
        check("b2b_phi1", p1, 32'd1);
        cap(8);
        check("p2_done", pd, 32'b00000001);
        cap(1);
        check("cnt2", period_cnt, 32'd2);
        cap(8);
        cap(1);
        check("cnt3", period_cnt, 32'd3);

        // Mid-period reconfiguration of ph2_len
        cap(5);
        check("rcfg_pre", p2, 32'b00001);
        ph2_len = 8'd6;
        cap(3);
        check("rcfg_cur", p2, 32'b110);
        check("rcfg_done", pd, 32'b001);
        cap(12);
        check("rcfg_phi1", p1, 32'b111100000000);
        check("rcfg_phi2", p2, 32'b000001111110);
        check("rcfg_done2", pd, 32'b000000000001);

        // Graceful stop from PHI1
        ph2_len = 8'd3;
        cap(1);
        check("stop_start", p1, 32'd1);
        enable = 1'b0;
        cap(8);
        check("stop_phi1", p1, 32'b11100000);
        check("stop_phi2", p2, 32'b00001110);
        check("stop_done", pd, 32'b00000001);
        check("stop_busy", pb, 32'hff);
        cap(2);
        check("stop_idle", pb | p1 | p2, 32'd0);
        check("stop_cnt", period_cnt, 32'd6);

        // Clamp with all-zero lengths
        ph1_len = 8'd0; nov_len = 8'd0; ph2_len = 8'd0; enable = 1'b1;
        ov = 1'b0;
        cap(10);
        check("clamp_phi1", p1, 32'b1100011000);
        check("clamp_phi1e", p1e, 32'b1000010000);
        check("clamp_phi2", p2, 32'b0001000010);
        check("clamp_done", pd, 32'b0000100001);
        check("clamp_overlap", {31'd0, ov}, 32'd0);

        // Asynchronous reset during PHI2
        ph1_len = 8'd4; nov_len = 8'd1; ph2_len = 8'd3;
        cap(6);
        check("ar_in_phi2", {31'd0, phi2}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_outs", {29'd0, phi2, busy, period_done}, 32'd0);
        check("ar_cnt", period_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cap(1);
        check("ar_restart", {29'd0, phi1, phi1e, busy}, 32'b111);
        check("ar_cnt0", period_cnt, 32'd0);

        // Counter wrap with 4-bit counter
        ph1_len = 8'd0; nov_len = 8'd0; ph2_len = 8'd0;
        dcount = 0;
        cap(8);
        check("wrap_p1", period_cnt, 32'd0);
        for (int i = 2; i <= 17; i++) begin
            cap(5);
            check("wrap_cnt", period_cnt, 32'((i - 1) % 16));
        end
        cap(1);
        check("wrap_after", period_cnt, 32'd1);
        check("wrap_pulses", dcount, 32'd17);
        enable = 1'b0;
        repeat (8) @(negedge clk);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_phase_clkgen.md
# sc_phase_clkgen

Non-overlapping two-phase clock generator that drives the phi1/phi2 switches of `switched_capacitor_filter`, sitting directly upstream of its sampling and integration capacitors. It derives phi1, phi2 and an early-phi1 (bottom-plate) phase from one system clock. Phase and gap lengths are programmable and are loaded only at period boundaries. It also reports completed filter periods to the digital back end.

## Interface
- `LEN_W`, default 8: width of the phase and gap length fields.
- `CNT_W`, default 16: width of the period counter.
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: run request, level-sensitive.
- `ph1_len` input LEN_W: phi1 high time in clk cycles; values below 2 are clamped to 2.
- `ph2_len` input LEN_W: phi2 high time in clk cycles; values below 1 are clamped to 1.
- `nov_len` input LEN_W: non-overlap gap after each phase; values below 1 are clamped to 1.
- `phi1` output 1: phase 1 switch drive.
- `phi1e` output 1: early phase 1; falls one cycle before phi1.
- `phi2` output 1: phase 2 switch drive.
- `period_done` output 1: one-cycle pulse on the last cycle of each period.
- `period_cnt` output CNT_W: number of completed periods; wraps modulo 2^CNT_W.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, PHI1, GAP12, PHI2, GAP21.
- A down-counter `rem` times each state.
- IDLE -> PHI1 when `enable` is sampled high. The clamped `ph1_len`, `ph2_len` and `nov_len` are latched into shadow registers on this transition.
- PHI1 lasts `ph1_s` cycles, then moves to GAP12.
- GAP12 lasts `nov_s` cycles, then moves to PHI2.
- PHI2 lasts `ph2_s` cycles, then moves to GAP21.
- GAP21 lasts `nov_s` cycles. On its last cycle:
  - `period_done` = 1 and `period_cnt` increments.
  - If `enable` = 1: go to PHI1 and re-latch the shadow registers.
  - Otherwise: go to IDLE.
- Dropping `enable` mid-period never truncates a phase. The current period completes through GAP21, then the FSM goes to IDLE.
- Raising `enable` during a wind-down has no effect; the FSM still goes to IDLE first.
- Input length changes take effect only at a latch point; mid-period changes are ignored.
- Output decode:
  - `phi1` = (state == PHI1).
  - `phi1e` = (state == PHI1) and not the last PHI1 cycle.
  - `phi2` = (state == PHI2).
  - `busy` = (state != IDLE).
- All outputs come directly from flops; there is no combinational path from the inputs to the outputs.
- Invariant: `phi1` and `phi2` are never high in the same cycle, and at least `nov_s` ≥ 1 low cycles always separate them.
- Period length = `ph1_s` + `ph2_s` + 2·`nov_s` cycles.
- Length arithmetic: clamps are applied at latch time. `rem` is LEN_W wide and is loaded with length−1.
- `period_cnt` wraps from 2^CNT_W−1 to 0 without flagging.

## Timing
- Reset values (asserted asynchronously, released synchronously to clk):
  - State IDLE, `rem` = 0, shadows = 0.
  - `phi1` = `phi1e` = `phi2` = 0, `period_done` = 0, `period_cnt` = 0, `busy` = 0.
- Start latency: `enable` is sampled high at edge k; `phi1`, `phi1e` and `busy` go high at edge k (registered next-state decode). From that point phi1 stays high for exactly `ph1_s` cycles.
- `phi1e` falls at the edge where the last PHI1 cycle begins, one edge before `phi1` falls.
- `period_done` is high for exactly one cycle, the final GAP21 cycle. `period_cnt` shows the new value from the following edge.
- Reset mid-operation: all outputs drop to their reset values immediately, asynchronously, and no pulse is emitted.
- Back-to-back periods have no dead cycle: the cycle after the last GAP21 cycle is PHI1.

## Test plan
- Basic sequence: reset, then `ph1_len`=4, `nov_len`=1, `ph2_len`=3, `enable`=1.
  - Required waveform: phi1 high for 4 cycles, phi1e high for the first 3 of them, 1 gap cycle, phi2 high for 3 cycles, 1 gap cycle.
  - `period_done` on cycle 9; `period_cnt` = 1, 2, 3 after each 9-cycle period.
- Clamp: lengths 0/0/0 -> phi1 = 2 cycles, phi1e = 1 cycle, gaps = 1, phi2 = 1; period = 5 cycles. A checker confirms phi1 & phi2 is never 1.
- Mid-period reconfiguration: change `ph2_len` from 3 to 6 during PHI2 -> current PHI2 stays 3 cycles; the next period's PHI2 is 6 cycles.
- Graceful stop: drop `enable` in PHI1 -> the period completes (phi2 still pulses), `period_done` fires, the FSM returns to IDLE with `busy` = 0, and `period_cnt` increments by exactly 1.
- Asynchronous reset: assert `rst_n` = 0 mid-PHI2 between clock edges -> phi2, busy and period_cnt = 0 immediately. After release with `enable` = 1, phi1 rises on the first clock edge.
- Counter wrap: run with CNT_W = 4 for 17 periods -> `period_cnt` goes 15 -> 0 -> 1, and `period_done` fires 17 times.
